pe_array_seq: RTL

- Initiator side of the PE control interface: generates the 2-bit wire-connection code stream and the matching vertical/horizontal bus operands consumed by a column of PEs.
- Buffers incoming operand pairs and accepts job commands (accumulate K steps, then format, then drain results down the chain).
- Plays out each job as a fixed, stall-free code sequence.
- Sits between the operand fetch logic and the PE array.

---
 rtl/pe_array_seq_if.sv | 39 +++
 rtl/pe_array_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pe_array_seq_if.sv
// Bundle of operand, command and PE-array control signals for pe_array_seq.
// The master modport is the sequencer's view; slave is the fetch/PE side.
interface pe_array_seq_if #(
    parameter int WIDTH_DATA = 16,
    parameter int DEPTH      = 16,
    parameter int ROW_W      = 8
);
    localparam int KW = $clog2(DEPTH) + 1;

    logic                  op_valid_i;
    logic                  op_ready_o;
    logic [WIDTH_DATA-1:0] op_v_data_i;
    logic [WIDTH_DATA-1:0] op_h_data_i;
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [KW-1:0]         cmd_k_i;
    logic [ROW_W-1:0]      cmd_rows_i;
    logic [1:0]            wire_connection_o;
    logic [WIDTH_DATA-1:0] v_bus_data_o;
    logic [WIDTH_DATA-1:0] h_bus_data_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        input  op_valid_i, op_v_data_i, op_h_data_i,
        input  cmd_valid_i, cmd_k_i, cmd_rows_i,
        output op_ready_o, cmd_ready_o,
        output wire_connection_o, v_bus_data_o, h_bus_data_o,
        output busy_o, done_o
    );

    modport slave (
        output op_valid_i, op_v_data_i, op_h_data_i,
        output cmd_valid_i, cmd_k_i, cmd_rows_i,
        input  op_ready_o, cmd_ready_o,
        input  wire_connection_o, v_bus_data_o, h_bus_data_o,
        input  busy_o, done_o
    );
endinterface

// File: rtl/pe_array_seq.sv
// PE-column sequencer: buffers operand pairs and plays each job out as a
// stall-free code stream (load, accumulate, format, drain) with bus data one cycle behind.
module pe_array_seq #(
    parameter int WIDTH_DATA = 16,
    parameter int DEPTH      = 16,
    parameter int FMT_CYCLES = 2,
    parameter int ROW_W      = 8
) (
    input logic          clk,
    input logic          rst,
    pe_array_seq_if.master pe
);
    localparam int AW  = $clog2(DEPTH);
    localparam int KW  = AW + 1;
    localparam int FW  = $clog2(FMT_CYCLES) + 1;
    localparam int CW0 = (ROW_W > KW) ? ROW_W : KW;
    localparam int CW  = (CW0 > FW) ? CW0 : FW;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_LOAD, S_ACC, S_FMT, S_DRAIN, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         step_q, step_d;
    logic [KW-1:0]         k_q, k_d, k_eff;
    logic [ROW_W-1:0]      rows_q, rows_d;
    logic [WIDTH_DATA-1:0] mem_v [DEPTH];
    logic [WIDTH_DATA-1:0] mem_h [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [KW-1:0]         count;
    logic [KW:0]           avail;
    logic                  op_ready, push, pop;
    logic [1:0]            code_d;
    logic [WIDTH_DATA-1:0] v_d, h_d;
    logic                  busy_d, done_d;
    logic                  wait_done;
    logic                  load_single;

    assign op_ready       = (count < KW'(DEPTH));
    assign push           = pe.op_valid_i & op_ready;
    assign pop            = (state_q == S_LOAD) || (state_q == S_ACC);
    assign avail          = {1'b0, count} + {{KW{1'b0}}, push};
    assign wait_done      = (avail >= {1'b0, k_q});
    assign load_single    = (k_q == KW'(1));
    assign pe.op_ready_o  = op_ready;
    assign pe.cmd_ready_o = (state_q == S_IDLE);

    always_comb begin
        k_eff = pe.cmd_k_i;
        if (pe.cmd_k_i == '0)
            k_eff = KW'(1);
        else if (pe.cmd_k_i > KW'(DEPTH))
            k_eff = KW'(DEPTH);
    end

    // Each timed state counts down step_q and leaves when it reaches zero.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        k_d     = k_q;
        rows_d  = rows_q;
        case (state_q)
            S_IDLE: if (pe.cmd_valid_i) begin
                state_d = S_WAIT;
                k_d     = k_eff;
                rows_d  = pe.cmd_rows_i;
            end
            S_WAIT: if (wait_done) state_d = S_LOAD;
            S_LOAD: if (load_single) begin
                state_d = S_FMT;
                step_d  = CW'(FMT_CYCLES - 1);
            end else begin
                state_d = S_ACC;
                step_d  = CW'(k_q) - CW'(2);
            end
            S_ACC: if (step_q == '0) begin
                state_d = S_FMT;
                step_d  = CW'(FMT_CYCLES - 1);
            end else begin
                step_d  = step_q - CW'(1);
            end
            S_FMT: if (step_q == '0) begin
                if (rows_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                    step_d  = CW'(rows_q) - CW'(1);
                end
            end else begin
                step_d  = step_q - CW'(1);
            end
            S_DRAIN: if (step_q == '0) state_d = S_DONE;
                     else step_d = step_q - CW'(1);
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_LOAD:  code_d = 2'd0;
            S_ACC:   code_d = 2'd1;
            S_DRAIN: code_d = 2'd2;
            default: code_d = 2'd3;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);

        // Operands popped now land on the buses next cycle, lagging their code.
        v_d = '0;
        h_d = '0;
        if (state_q == S_LOAD) begin
            v_d = mem_v[rd_ptr];
            h_d = mem_h[rd_ptr];
        end else if (state_q == S_ACC) begin
            h_d = mem_h[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_v[wr_ptr] <= pe.op_v_data_i;
            mem_h[wr_ptr] <= pe.op_h_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q              <= S_IDLE;
            step_q               <= '0;
            k_q                  <= KW'(1);
            rows_q               <= '0;
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            count                <= '0;
            pe.wire_connection_o <= 2'd3;
            pe.v_bus_data_o      <= '0;
            pe.h_bus_data_o      <= '0;
            pe.busy_o            <= 1'b0;
            pe.done_o            <= 1'b0;
        end else begin
            state_q              <= state_d;
            step_q               <= step_d;
            k_q                  <= k_d;
            rows_q               <= rows_d;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + KW'(1);
            else if (!push && pop) count <= count - KW'(1);
            pe.wire_connection_o <= code_d;
            pe.v_bus_data_o      <= v_d;
            pe.h_bus_data_o      <= h_d;
            pe.busy_o            <= busy_d;
            pe.done_o            <= done_d;
        end
    end
endmodule
